// File: rtl/wm_cycle_ctrl.sv
// wm_cycle_ctrl: washing-machine cycle sequencer.
//
// Holds the front-panel configuration (water level, temperature, rinse
// count). On start it runs FILL_W -> WASH -> DRAIN_W -> (FILL_R -> RINSE ->
// DRAIN_R) x rinse count -> DRY -> DONE -> IDLE on a 1 s tick made by a
// TICK_DIV prescaler.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   btn_start/water/temp/repeat  debounced single-cycle button pulses
//   red_led_*                 phase / valve / repeat indicators
//   green_led_*               one-hot config display
//   valve_hot, valve_cold, motor_on, drain_on   actuator enables
//   busy, done                sequencer status
//   sec_left                  seconds remaining in the current phase
//   rinse_left                rinse passes remaining, current pass included
//
// Optional build macro: WM_PAUSE_EN. When defined, btn_start while running
// (not in DONE) toggles a pause that freezes timing and drops all actuators.
// When undefined, btn_start while running is ignored.
//
// All LED/actuator/status outputs are registered; their register inputs are
// decoded from the next state and next config so they appear the cycle after
// the causing edge, exactly as a decode of the state register would.

module wm_cycle_ctrl #(
  parameter int unsigned TICK_DIV   = 125000000,
  parameter int unsigned FILL_SEC_L = 2,
  parameter int unsigned FILL_SEC_M = 3,
  parameter int unsigned FILL_SEC_H = 4,
  parameter int unsigned WASH_SEC   = 10,
  parameter int unsigned RINSE_SEC  = 6,
  parameter int unsigned DRAIN_SEC  = 2,
  parameter int unsigned DRY_SEC    = 8,
  parameter int unsigned DONE_SEC   = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn_start,
  input  logic       btn_water,
  input  logic       btn_temp,
  input  logic       btn_repeat,
  output logic       red_led_wash,
  output logic       red_led_rinse,
  output logic       red_led_dry,
  output logic       red_led_repeat,
  output logic       red_led_water_height,
  output logic       red_led_hot_cold,
  output logic       green_led_water_high,
  output logic       green_led_water_mid,
  output logic       green_led_water_low,
  output logic       green_led_hot_only,
  output logic       green_led_cold_only,
  output logic       green_led_hot_cold,
  output logic       valve_hot,
  output logic       valve_cold,
  output logic       motor_on,
  output logic       drain_on,
  output logic       busy,
  output logic       done,
  output logic [7:0] sec_left,
  output logic [1:0] rinse_left
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] LVL_LOW  = 2'd0;
  localparam logic [1:0] LVL_MID  = 2'd1;
  localparam logic [1:0] LVL_HIGH = 2'd2;
  localparam logic [1:0] TMP_HOT  = 2'd0;
  localparam logic [1:0] TMP_COLD = 2'd1;
  localparam logic [1:0] TMP_BOTH = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FILL_W  = 4'd1,
    S_WASH    = 4'd2,
    S_DRAIN_W = 4'd3,
    S_FILL_R  = 4'd4,
    S_RINSE   = 4'd5,
    S_DRAIN_R = 4'd6,
    S_DRY     = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  typedef struct packed {
    logic led_wash;
    logic led_rinse;
    logic led_dry;
    logic led_repeat;
    logic led_water_height;
    logic led_hot_cold;
    logic g_water_high;
    logic g_water_mid;
    logic g_water_low;
    logic g_hot_only;
    logic g_cold_only;
    logic g_hot_cold;
    logic v_hot;
    logic v_cold;
    logic motor;
    logic drain;
    logic busy;
    logic done;
  } out_t;

  state_t        state, state_nx;
  logic [1:0]    water, water_nx;
  logic [1:0]    temp, temp_nx;
  logic [1:0]    rpt, rpt_nx;
  logic [1:0]    run_temp, run_temp_nx;   // temperature latched at start
  logic [7:0]    fill_sec, fill_nx;       // fill length latched at start
  logic [PW-1:0] presc, presc_nx;
  logic [7:0]    sec_nx;
  logic [1:0]    rinse_nx;
  logic          tick;
  logic          run;
  out_t          out_d, out_q;

`ifdef WM_PAUSE_EN
  logic paused, paused_nx;
  logic pause_tog;
  assign pause_tog = btn_start && (state != S_IDLE) && (state != S_DONE);
  assign run       = !paused && !pause_tog;
`else
  assign run = 1'b1;
`endif

  assign tick = (presc == TICK_LAST);

  // Wrapping step through [lo..hi].
  function automatic logic [1:0] step3(input logic [1:0] v, input logic [1:0] lo,
                                       input logic [1:0] hi);
    return (v == hi) ? lo : v + 2'd1;
  endfunction

  function automatic logic [7:0] fill_len(input logic [1:0] lvl);
    case (lvl)
      LVL_LOW:  return 8'(FILL_SEC_L);
      LVL_HIGH: return 8'(FILL_SEC_H);
      default:  return 8'(FILL_SEC_M);
    endcase
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      water      <= LVL_MID;
      temp       <= TMP_BOTH;
      rpt        <= 2'd1;
      run_temp   <= TMP_BOTH;
      fill_sec   <= 8'd0;
      presc      <= '0;
      sec_left   <= 8'd0;
      rinse_left <= 2'd0;
`ifdef WM_PAUSE_EN
      paused     <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      water      <= water_nx;
      temp       <= temp_nx;
      rpt        <= rpt_nx;
      run_temp   <= run_temp_nx;
      fill_sec   <= fill_nx;
      presc      <= presc_nx;
      sec_left   <= sec_nx;
      rinse_left <= rinse_nx;
`ifdef WM_PAUSE_EN
      paused     <= paused_nx;
`endif
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q             <= '0;
      out_q.g_water_mid <= 1'b1;
      out_q.g_hot_cold  <= 1'b1;
    end else begin
      out_q <= out_d;
    end
  end

  // Next-state, config and phase timing.
  always_comb begin : next_state
    state_nx    = state;
    water_nx    = water;
    temp_nx     = temp;
    rpt_nx      = rpt;
    run_temp_nx = run_temp;
    fill_nx     = fill_sec;
    presc_nx    = presc;
    sec_nx      = sec_left;
    rinse_nx    = rinse_left;
`ifdef WM_PAUSE_EN
    paused_nx   = paused ^ pause_tog;
`endif
    if (state == S_IDLE) begin
      if (btn_water)  water_nx = step3(water, LVL_LOW, LVL_HIGH);
      if (btn_temp)   temp_nx  = step3(temp, TMP_HOT, TMP_BOTH);
      if (btn_repeat) rpt_nx   = step3(rpt, 2'd1, 2'd3);
      // Start uses the config as it was before this edge.
      if (btn_start) begin
        state_nx    = S_FILL_W;
        presc_nx    = '0;
        sec_nx      = fill_len(water);
        fill_nx     = fill_len(water);
        rinse_nx    = rpt;
        run_temp_nx = temp;
      end
    end else if (run) begin
      presc_nx = tick ? '0 : presc + PW'(1);
      if (tick) begin
        if (sec_left != 8'd1) begin
          sec_nx = sec_left - 8'd1;
        end else begin
          case (state)
            S_FILL_W:  begin state_nx = S_WASH;    sec_nx = 8'(WASH_SEC);  end
            S_WASH:    begin state_nx = S_DRAIN_W; sec_nx = 8'(DRAIN_SEC); end
            S_DRAIN_W: begin state_nx = S_FILL_R;  sec_nx = fill_sec;      end
            S_FILL_R:  begin state_nx = S_RINSE;   sec_nx = 8'(RINSE_SEC); end
            S_RINSE:   begin state_nx = S_DRAIN_R; sec_nx = 8'(DRAIN_SEC); end
            S_DRAIN_R: begin
              if (rinse_left > 2'd1) begin
                state_nx = S_FILL_R;
                sec_nx   = fill_sec;
                rinse_nx = rinse_left - 2'd1;
              end else begin
                state_nx = S_DRY;
                sec_nx   = 8'(DRY_SEC);
              end
            end
            S_DRY:     begin state_nx = S_DONE;    sec_nx = 8'(DONE_SEC);  end
            S_DONE: begin
              state_nx  = S_IDLE;
              sec_nx    = 8'd0;
              presc_nx  = '0;
`ifdef WM_PAUSE_EN
              paused_nx = 1'b0;
`endif
            end
            default:   begin state_nx = S_IDLE;    sec_nx = 8'd0;          end
          endcase
        end
      end
    end
  end

  // Output decode from next state and next config.
  always_comb begin : out_decode
    out_d = '0;
    case (state_nx)
      S_FILL_W: begin
        out_d.v_hot    = (run_temp_nx != TMP_COLD);
        out_d.v_cold   = (run_temp_nx != TMP_HOT);
        out_d.led_wash = 1'b1;
      end
      S_WASH:    begin out_d.motor  = 1'b1; out_d.led_wash  = 1'b1; end
      S_DRAIN_W: begin out_d.drain  = 1'b1; out_d.led_wash  = 1'b1; end
      S_FILL_R:  begin out_d.v_cold = 1'b1; out_d.led_rinse = 1'b1; end
      S_RINSE:   begin out_d.motor  = 1'b1; out_d.led_rinse = 1'b1; end
      S_DRAIN_R: begin out_d.drain  = 1'b1; out_d.led_rinse = 1'b1; end
      S_DRY: begin
        out_d.motor   = 1'b1;
        out_d.drain   = 1'b1;
        out_d.led_dry = 1'b1;
      end
      S_DONE: begin
        out_d.led_wash  = 1'b1;
        out_d.led_rinse = 1'b1;
        out_d.led_dry   = 1'b1;
        out_d.done      = 1'b1;
      end
      default: ;
    endcase
`ifdef WM_PAUSE_EN
    // Paused: actuators off, phase LEDs untouched.
    if (paused_nx) begin
      out_d.v_hot  = 1'b0;
      out_d.v_cold = 1'b0;
      out_d.motor  = 1'b0;
      out_d.drain  = 1'b0;
    end
`endif
    out_d.led_water_height = out_d.v_hot | out_d.v_cold;
    out_d.led_hot_cold     = out_d.v_hot;
    out_d.busy             = (state_nx != S_IDLE);
    out_d.led_repeat       = (rpt_nx != 2'd1);
    out_d.g_water_high     = (water_nx == LVL_HIGH);
    out_d.g_water_mid      = (water_nx == LVL_MID);
    out_d.g_water_low      = (water_nx == LVL_LOW);
    out_d.g_hot_only       = (temp_nx == TMP_HOT);
    out_d.g_cold_only      = (temp_nx == TMP_COLD);
    out_d.g_hot_cold       = (temp_nx == TMP_BOTH);
  end

  assign red_led_wash         = out_q.led_wash;
  assign red_led_rinse        = out_q.led_rinse;
  assign red_led_dry          = out_q.led_dry;
  assign red_led_repeat       = out_q.led_repeat;
  assign red_led_water_height = out_q.led_water_height;
  assign red_led_hot_cold     = out_q.led_hot_cold;
  assign green_led_water_high = out_q.g_water_high;
  assign green_led_water_mid  = out_q.g_water_mid;
  assign green_led_water_low  = out_q.g_water_low;
  assign green_led_hot_only   = out_q.g_hot_only;
  assign green_led_cold_only  = out_q.g_cold_only;
  assign green_led_hot_cold   = out_q.g_hot_cold;
  assign valve_hot            = out_q.v_hot;
  assign valve_cold           = out_q.v_cold;
  assign motor_on             = out_q.motor;
  assign drain_on             = out_q.drain;
  assign busy                 = out_q.busy;
  assign done                 = out_q.done;

endmodule

// File: tb/tb_wm_cycle_ctrl.sv
// Scoreboard bench for wm_cycle_ctrl with a shortened timebase.
// Snapshot layout: {rinse_left[27:26], sec_left[25:18], 18 status bits}.
module tb_wm_cycle_ctrl;

  logic clk = 1'b0;
  logic rstn;
  logic btn_start, btn_water, btn_temp, btn_repeat;
  logic red_led_wash, red_led_rinse, red_led_dry, red_led_repeat;
  logic red_led_water_height, red_led_hot_cold;
  logic green_led_water_high, green_led_water_mid, green_led_water_low;
  logic green_led_hot_only, green_led_cold_only, green_led_hot_cold;
  logic valve_hot, valve_cold, motor_on, drain_on, busy, done;
  logic [7:0] sec_left;
  logic [1:0] rinse_left;

  always #4 clk = ~clk;

  wm_cycle_ctrl #(
    .TICK_DIV(4), .FILL_SEC_L(1), .FILL_SEC_M(2), .FILL_SEC_H(3),
    .WASH_SEC(3), .RINSE_SEC(2), .DRAIN_SEC(1), .DRY_SEC(2), .DONE_SEC(1)
  ) dut (
    .clk(clk), .rstn(rstn),
    .btn_start(btn_start), .btn_water(btn_water), .btn_temp(btn_temp),
    .btn_repeat(btn_repeat),
    .red_led_wash(red_led_wash), .red_led_rinse(red_led_rinse),
    .red_led_dry(red_led_dry), .red_led_repeat(red_led_repeat),
    .red_led_water_height(red_led_water_height),
    .red_led_hot_cold(red_led_hot_cold),
    .green_led_water_high(green_led_water_high),
    .green_led_water_mid(green_led_water_mid),
    .green_led_water_low(green_led_water_low),
    .green_led_hot_only(green_led_hot_only),
    .green_led_cold_only(green_led_cold_only),
    .green_led_hot_cold(green_led_hot_cold),
    .valve_hot(valve_hot), .valve_cold(valve_cold),
    .motor_on(motor_on), .drain_on(drain_on),
    .busy(busy), .done(done), .sec_left(sec_left), .rinse_left(rinse_left)
  );

  localparam logic [27:0] F_GHC  = 28'h1;
  localparam logic [27:0] F_GCO  = 28'h2;
  localparam logic [27:0] F_GHO  = 28'h4;
  localparam logic [27:0] F_GLO  = 28'h8;
  localparam logic [27:0] F_GMID = 28'h10;
  localparam logic [27:0] F_GHI  = 28'h20;
  localparam logic [27:0] F_RHC  = 28'h40;
  localparam logic [27:0] F_RWH  = 28'h80;
  localparam logic [27:0] F_RREP = 28'h100;
  localparam logic [27:0] F_RD   = 28'h200;
  localparam logic [27:0] F_RR   = 28'h400;
  localparam logic [27:0] F_RW   = 28'h800;
  localparam logic [27:0] F_DRN  = 28'h1000;
  localparam logic [27:0] F_MOT  = 28'h2000;
  localparam logic [27:0] F_VC   = 28'h4000;
  localparam logic [27:0] F_VH   = 28'h8000;
  localparam logic [27:0] F_DONE = 28'h10000;
  localparam logic [27:0] F_BUSY = 28'h20000;
  localparam logic [27:0] M_FLAGS = 28'h003FFFF;
  localparam logic [27:0] M_NORIN = 28'h3FFFFFF;
  localparam logic [27:0] M_ALL   = 28'hFFFFFFF;
  localparam logic [27:0] DEF     = F_GMID | F_GHC;
  localparam logic [27:0] FW_DEF  = F_BUSY | F_VH | F_VC | F_RW | F_RWH | F_RHC;

  typedef struct {
    int unsigned at;
    logic [27:0] mask;
    logic [27:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned done_q[$];
  int unsigned ecnt = 0;
  int          checks = 0;
  int          errors = 0;
  logic        rst_pend = 1'b0;
  logic [27:0] rst_exp = '0;
  logic        finish_req = 1'b0;
  logic        done_d = 1'b0;

  always @(posedge clk) ecnt <= ecnt + 1;

  function automatic logic [27:0] snap();
    return {rinse_left, sec_left, busy, done, valve_hot, valve_cold, motor_on,
            drain_on, red_led_wash, red_led_rinse, red_led_dry, red_led_repeat,
            red_led_water_height, red_led_hot_cold, green_led_water_high,
            green_led_water_mid, green_led_water_low, green_led_hot_only,
            green_led_cold_only, green_led_hot_cold};
  endfunction

  function automatic logic [27:0] v(input logic [27:0] f, input int unsigned s,
                                    input int unsigned r);
    return f | (28'(s) << 18) | (28'(r) << 26);
  endfunction

  // Insert keeping the queue ordered by due cycle.
  function automatic void expect_at(input int unsigned at, input logic [27:0] mask,
                                    input logic [27:0] val, input string name);
    exp_t e;
    int   i;
    e.at = at; e.mask = mask; e.val = val; e.name = name;
    i = 0;
    while (i < sb.size() && sb[i].at <= at) i++;
    sb.insert(i, e);
  endfunction

  // Monitor: samples 1 time unit after each falling clk or rstn edge.
  always begin
    exp_t e;
    @(negedge clk or negedge rstn);
    #1;
    while (sb.size() > 0 && sb[0].at <= ecnt) begin
      e = sb.pop_front();
      checks++;
      if (e.at != ecnt || (snap() & e.mask) != (e.val & e.mask)) begin
        errors++;
        $display("FAIL %s: cycle %0d (due %0d) got %07h want %07h mask %07h",
                 e.name, ecnt, e.at, snap() & e.mask, e.val & e.mask, e.mask);
      end
    end
    if (rst_pend && !rstn) begin
      rst_pend = 1'b0;
      checks++;
      if (snap() != rst_exp) begin
        errors++;
        $display("FAIL async_reset: got %07h want %07h", snap(), rst_exp);
      end
    end
    if (done && !done_d) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL done_rise: unexpected at cycle %0d", ecnt);
      end else if (done_q[0] != ecnt) begin
        errors++;
        $display("FAIL done_rise: cycle %0d want %0d", ecnt, done_q[0]);
        void'(done_q.pop_front());
      end else begin
        void'(done_q.pop_front());
      end
    end
    done_d = done;
    if (finish_req) begin
      foreach (sb[i]) begin
        checks++;
        errors++;
        $display("FAIL %s: never sampled, due cycle %0d", sb[i].name, sb[i].at);
      end
      foreach (done_q[i]) begin
        checks++;
        errors++;
        $display("FAIL done_rise: no done, want cycle %0d", done_q[i]);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  // Called at a falling edge: the next rising edge samples the pulse.
  task automatic pulse(input logic s, input logic w, input logic t, input logic r);
    btn_start = s; btn_water = w; btn_temp = t; btn_repeat = r;
    @(negedge clk);
    btn_start = 1'b0; btn_water = 1'b0; btn_temp = 1'b0; btn_repeat = 1'b0;
  endtask

  task automatic wait_to(input int unsigned t);
    while (ecnt < t) @(negedge clk);
  endtask

  initial begin
    int unsigned s;
    logic [27:0] g;
    rstn = 1'b0;
    btn_start = 1'b0; btn_water = 1'b0; btn_temp = 1'b0; btn_repeat = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Reset defaults
    expect_at(ecnt + 1, M_ALL, DEF, "reset_defaults");
    repeat (2) @(negedge clk);

    // Config stepping in IDLE, with wraps back to defaults
    expect_at(ecnt + 1, M_FLAGS, F_GHI | F_GHC, "water_to_high");
    pulse(0, 1, 0, 0);
    expect_at(ecnt + 1, M_FLAGS, F_GLO | F_GHC, "water_to_low");
    pulse(0, 1, 0, 0);
    expect_at(ecnt + 1, M_FLAGS, F_GLO | F_GHO, "temp_to_hot_only");
    pulse(0, 0, 1, 0);
    expect_at(ecnt + 1, M_FLAGS, F_GLO | F_GCO, "temp_to_cold_only");
    pulse(0, 0, 1, 0);
    expect_at(ecnt + 1, M_FLAGS, F_GLO | F_GCO | F_RREP, "repeat_to_2");
    pulse(0, 0, 0, 1);
    expect_at(ecnt + 1, M_FLAGS, F_GLO | F_GCO | F_RREP, "repeat_to_3");
    pulse(0, 0, 0, 1);
    expect_at(ecnt + 1, M_FLAGS, F_GLO | F_GCO, "repeat_wrap_to_1");
    pulse(0, 0, 0, 1);
    expect_at(ecnt + 1, M_FLAGS, F_GLO | F_GHC, "temp_wrap");
    pulse(0, 0, 1, 0);
    expect_at(ecnt + 1, M_FLAGS, DEF, "water_wrap");
    pulse(0, 1, 0, 0);
    repeat (2) @(negedge clk);

    // Default full run
    s = ecnt;
    expect_at(s + 1,  M_ALL, v(FW_DEF | DEF, 2, 1), "run_fill_w");
    expect_at(s + 5,  M_ALL, v(FW_DEF | DEF, 1, 1), "run_fill_w_tick");
    expect_at(s + 8,  M_ALL, v(FW_DEF | DEF, 1, 1), "run_fill_w_last");
    expect_at(s + 9,  M_ALL, v(F_BUSY | F_MOT | F_RW | DEF, 3, 1), "run_wash");
    expect_at(s + 12, M_FLAGS, F_BUSY | F_MOT | F_RW | DEF, "cfg_ignored_busy");
    expect_at(s + 21, M_ALL, v(F_BUSY | F_DRN | F_RW | DEF, 1, 1), "run_drain_w");
    expect_at(s + 25, M_ALL, v(F_BUSY | F_VC | F_RR | F_RWH | DEF, 2, 1), "run_fill_r");
    expect_at(s + 33, M_ALL, v(F_BUSY | F_MOT | F_RR | DEF, 2, 1), "run_rinse");
    expect_at(s + 41, M_ALL, v(F_BUSY | F_DRN | F_RR | DEF, 1, 1), "run_drain_r");
    expect_at(s + 45, M_ALL, v(F_BUSY | F_MOT | F_DRN | F_RD | DEF, 2, 1), "run_dry");
    expect_at(s + 52, M_ALL, v(F_BUSY | F_MOT | F_DRN | F_RD | DEF, 1, 1), "run_dry_last");
    expect_at(s + 53, M_ALL, v(F_BUSY | F_DONE | F_RW | F_RR | F_RD | DEF, 1, 1), "run_done");
    expect_at(s + 57, M_NORIN, v(DEF, 0, 0), "run_idle");
    done_q.push_back(s + 53);
    pulse(1, 0, 0, 0);
    wait_to(s + 10);
    pulse(0, 1, 1, 1);
`ifndef WM_PAUSE_EN
    wait_to(s + 14);
    expect_at(s + 16, M_ALL, v(F_BUSY | F_MOT | F_RW | DEF, 2, 1), "start_ignored_busy");
    pulse(1, 0, 0, 0);
`endif
    wait_to(s + 60);

    // Repeat = 3, start together with a water press (run keeps mid level)
    expect_at(ecnt + 1, M_FLAGS, DEF | F_RREP, "repeat_2_for_run");
    pulse(0, 0, 0, 1);
    pulse(0, 0, 0, 1);
    s = ecnt;
    g = F_RREP | F_GHI | F_GHC;
    expect_at(s + 1,  M_ALL, v(FW_DEF | g, 2, 3), "r3_fill_w");
    expect_at(s + 25, M_ALL, v(F_BUSY | F_VC | F_RR | F_RWH | g, 2, 3), "r3_fill_r1");
    expect_at(s + 41, M_ALL, v(F_BUSY | F_DRN | F_RR | g, 1, 3), "r3_drain_r1");
    expect_at(s + 45, M_ALL, v(F_BUSY | F_VC | F_RR | F_RWH | g, 2, 2), "r3_fill_r2");
    expect_at(s + 61, M_ALL, v(F_BUSY | F_DRN | F_RR | g, 1, 2), "r3_drain_r2");
    expect_at(s + 65, M_ALL, v(F_BUSY | F_VC | F_RR | F_RWH | g, 2, 1), "r3_fill_r3");
    expect_at(s + 85, M_ALL, v(F_BUSY | F_MOT | F_DRN | F_RD | g, 2, 1), "r3_dry");
    expect_at(s + 93, M_ALL, v(F_BUSY | F_DONE | F_RW | F_RR | F_RD | g, 1, 1), "r3_done");
    expect_at(s + 97, M_NORIN, v(g, 0, 0), "r3_idle");
    done_q.push_back(s + 93);
    pulse(1, 1, 0, 0);
    wait_to(s + 100);

    // Reset mid-WASH (high level: WASH from cycle 13)
    s = ecnt;
    expect_at(s + 15, M_FLAGS, F_BUSY | F_MOT | F_RW | F_RREP | F_GHI | F_GHC, "wash_before_reset");
    pulse(1, 0, 0, 0);
    wait_to(s + 16);
    rst_exp  = DEF;
    rst_pend = 1'b1;
    rstn     = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    expect_at(ecnt + 1, M_ALL, DEF, "reset_release");
    expect_at(ecnt + 8, M_ALL, DEF, "stays_idle");
    repeat (10) @(negedge clk);

`ifdef WM_PAUSE_EN
    // Pause 2 cycles into WASH, resume 21 cycles later
    s = ecnt;
    expect_at(s + 9,  M_ALL, v(F_BUSY | F_MOT | F_RW | DEF, 3, 1), "p_wash");
    expect_at(s + 11, M_ALL, v(F_BUSY | F_RW | DEF, 3, 1), "p_paused");
    expect_at(s + 30, M_ALL, v(F_BUSY | F_RW | DEF, 3, 1), "p_paused_hold");
    expect_at(s + 32, M_ALL, v(F_BUSY | F_MOT | F_RW | DEF, 3, 1), "p_resumed");
    expect_at(s + 35, M_ALL, v(F_BUSY | F_MOT | F_RW | DEF, 2, 1), "p_first_tick");
    expect_at(s + 75, M_ALL, v(F_BUSY | F_DONE | F_RW | F_RR | F_RD | DEF, 1, 1), "p_done");
    expect_at(s + 79, M_NORIN, v(DEF, 0, 0), "p_idle");
    done_q.push_back(s + 75);
    pulse(1, 0, 0, 0);
    wait_to(s + 10);
    pulse(1, 0, 0, 0);
    wait_to(s + 31);
    pulse(1, 0, 0, 0);
    wait_to(s + 85);
`endif

    finish_req = 1'b1;
  end

endmodule
